// File: rtl/axi_pkg.sv
// Shared AXI definitions: FSM encodings, burst and response codes.
// Used by both the read-path and write-path protocol models.
package axi_pkg;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_VALID = 1'b1
  } ar_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// Next-beat address generator for FIXED/INCR/WRAP bursts.
// Illegal wrap lengths and the reserved burst type fall back to INCR.
module axi_beat_addr
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] start,
  input  logic [7:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] span;
  logic [AW-1:0] mask;
  logic [AW-1:0] base;
  logic          wrap_hit;

  always_comb begin
    step     = AW'(1) << size;
    span     = AW'({1'b0, len} + 9'd1) << size;
    mask     = span - AW'(1);
    base     = start & ~mask;
    wrap_hit = (burst == BURST_WRAP) && wrap_len_ok(len);
    next_addr = addr + step;
    unique case (1'b1)
      (burst == BURST_FIXED): next_addr = addr;
      wrap_hit: next_addr = base + ((addr + step - base) & mask);
      default: next_addr = addr + step;
    endcase
  end

endmodule

// File: rtl/axi_read_protocol.sv
// AXI read-path model: AR handshake then an arlen+1 beat R burst,
// one burst outstanding, payload held stable under backpressure.
module axi_read_protocol
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          axi_aclk,
  input  logic          axi_aresetn,
  input  logic [AW-1:0] araddr_in,
  input  logic [7:0]    arlen_in,
  input  logic [2:0]    arsize_in,
  input  logic [1:0]    arburst_in,
  input  logic          arvalid_in,
  input  logic [DW-1:0] rdata_in,
  input  logic [1:0]    rresp_in,
  input  logic          rvalid_in,
  input  logic          rready_in,
  output logic [AW-1:0] axi_araddr,
  output logic [7:0]    axi_arlen,
  output logic [2:0]    axi_arsize,
  output logic [1:0]    axi_arburst,
  output logic          axi_arvalid,
  output logic          axi_arready,
  output logic [DW-1:0] axi_rdata,
  output logic [1:0]    axi_rresp,
  output logic          axi_rlast,
  output logic          axi_rvalid,
  output logic          axi_rready,
  output logic [AW-1:0] beat_addr
);

  ar_state_t     ar_state;
  r_state_t      r_state;
  logic          r_active;
  logic [7:0]    beat_cnt;
  logic [AW-1:0] b_start;
  logic [7:0]    b_len;
  logic [2:0]    b_size;
  logic [1:0]    b_burst;
  logic [AW-1:0] next_addr;
  logic          ar_hs;
  logic          r_hs;
  logic          ar_cap;

  assign ar_hs  = axi_arvalid & axi_arready;
  assign r_hs   = axi_rvalid & axi_rready;
  assign ar_cap = arvalid_in & ((ar_state == AR_IDLE) | ar_hs);

  axi_beat_addr #(.AW(AW)) u_beat_addr (
    .addr      (beat_addr),
    .start     (b_start),
    .len       (b_len),
    .size      (b_size),
    .burst     (b_burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      ar_state    <= AR_IDLE;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
      axi_arburst <= '0;
      axi_arvalid <= 1'b0;
    end else begin
      if (ar_cap) begin
        axi_araddr  <= araddr_in;
        axi_arlen   <= arlen_in;
        axi_arsize  <= arsize_in;
        axi_arburst <= arburst_in;
      end
      unique case (ar_state)
        AR_IDLE: begin
          if (arvalid_in) begin
            axi_arvalid <= 1'b1;
            ar_state    <= AR_VALID;
          end
        end
        AR_VALID: begin
          if (ar_hs && !arvalid_in) begin
            axi_arvalid <= 1'b0;
            ar_state    <= AR_IDLE;
          end
        end
      endcase
    end
  end

  // Burst attributes are snapshotted at the AR handshake so a queued
  // second request cannot disturb the address walk of the live burst.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state     <= R_IDLE;
      axi_rdata   <= '0;
      axi_rresp   <= '0;
      axi_rlast   <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rready  <= 1'b0;
      axi_arready <= 1'b1;
      r_active    <= 1'b0;
      beat_cnt    <= '0;
      beat_addr   <= '0;
      b_start     <= '0;
      b_len       <= '0;
      b_size      <= '0;
      b_burst     <= '0;
    end else begin
      axi_rready <= rready_in;
      if (ar_hs) begin
        r_active    <= 1'b1;
        axi_arready <= 1'b0;
        beat_cnt    <= axi_arlen;
        beat_addr   <= axi_araddr;
        b_start     <= axi_araddr;
        b_len       <= axi_arlen;
        b_size      <= axi_arsize;
        b_burst     <= axi_arburst;
      end
      unique case (r_state)
        R_IDLE: begin
          if (r_active && rvalid_in) begin
            axi_rdata  <= rdata_in;
            axi_rresp  <= rresp_in;
            axi_rlast  <= (beat_cnt == 8'd0);
            axi_rvalid <= 1'b1;
            r_state    <= R_VALID;
          end
        end
        R_VALID: begin
          if (r_hs) begin
            if (axi_rlast) begin
              r_active    <= 1'b0;
              axi_arready <= 1'b1;
              axi_rvalid  <= 1'b0;
              axi_rlast   <= 1'b0;
              r_state     <= R_IDLE;
            end else begin
              beat_cnt  <= beat_cnt - 8'd1;
              beat_addr <= next_addr;
              if (rvalid_in) begin
                axi_rdata <= rdata_in;
                axi_rresp <= rresp_in;
                axi_rlast <= (beat_cnt == 8'd1);
              end else begin
                axi_rvalid <= 1'b0;
                r_state    <= R_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_protocol.sv
// Directed bench for axi_read_protocol: AR/R handshakes, backpressure,
// wrap addressing, queued request, error response and mid-burst reset.
module tb_axi_read_protocol;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn;
  logic [AW-1:0] araddr_in;
  logic [7:0]    arlen_in;
  logic [2:0]    arsize_in;
  logic [1:0]    arburst_in;
  logic          arvalid_in;
  logic [DW-1:0] rdata_in;
  logic [1:0]    rresp_in;
  logic          rvalid_in;
  logic          rready_in;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;
  logic [AW-1:0] beat_addr;

  always #5 axi_aclk = ~axi_aclk;

  axi_read_protocol #(.AW(AW), .DW(DW)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .araddr_in   (araddr_in),
    .arlen_in    (arlen_in),
    .arsize_in   (arsize_in),
    .arburst_in  (arburst_in),
    .arvalid_in  (arvalid_in),
    .rdata_in    (rdata_in),
    .rresp_in    (rresp_in),
    .rvalid_in   (rvalid_in),
    .rready_in   (rready_in),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .beat_addr   (beat_addr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [AW-1:0] addr;
  } beat_t;

  beat_t         q[$];
  int            nvec = 0;
  int            nmis = 0;
  int            ar_cnt = 0;
  logic          rr_mode = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] p_data;
  logic          p_last;
  logic [AW-1:0] p_addr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rdata_in = 64'h5000;
    forever begin
      @(posedge axi_aclk);
      #1 rdata_in = rdata_in + 64'd1;
    end
  end

  initial begin
    int k = 0;
    forever begin
      @(posedge axi_aclk);
      #1;
      if (rr_mode) begin
        rready_in = (k % 3 == 0);
        k++;
      end
    end
  end

  // Observe handshakes and payload hold at the falling edge.
  initial begin
    forever begin
      @(negedge axi_aclk);
      if (axi_aresetn !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(axi_rvalid), 64'd1);
          check("hold_data", axi_rdata, p_data);
          check("hold_last", 64'(axi_rlast), 64'(p_last));
          check("hold_addr", 64'(beat_addr), 64'(p_addr));
        end
        if (axi_rvalid && axi_rready)
          q.push_back('{axi_rdata, axi_rresp, axi_rlast, beat_addr});
        if (axi_arvalid && axi_arready)
          ar_cnt++;
        prev_stall = axi_rvalid && !axi_rready;
        p_data = axi_rdata;
        p_last = axi_rlast;
        p_addr = beat_addr;
      end
    end
  end

  task automatic req(input logic [AW-1:0] a, input logic [7:0] l,
                     input logic [2:0] s, input logic [1:0] b);
    @(negedge axi_aclk);
    araddr_in  = a;
    arlen_in   = l;
    arsize_in  = s;
    arburst_in = b;
    arvalid_in = 1'b1;
    @(posedge axi_aclk);
    #1 arvalid_in = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge axi_aclk);
      if (q.size() >= n) break;
    end
    #2;
    if (i == 300) check("beat_timeout", 64'(q.size()), 64'(n));
  endtask

  task automatic chk_beat(input int i, input logic [AW-1:0] a,
                          input logic l);
    check($sformatf("addr%0d", i), 64'(q[i].addr), 64'(a));
    check($sformatf("last%0d", i), 64'(q[i].last), 64'(l));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    axi_aresetn = 1'b0;
    araddr_in   = '0;
    arlen_in    = '0;
    arsize_in   = '0;
    arburst_in  = '0;
    arvalid_in  = 1'b0;
    rresp_in    = RESP_OKAY;
    rvalid_in   = 1'b0;
    rready_in   = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1;
    check("rst_arready", 64'(axi_arready), 64'd1);
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_rvalid", 64'(axi_rvalid), 64'd0);
    check("rst_rlast", 64'(axi_rlast), 64'd0);
    check("rst_rready", 64'(axi_rready), 64'd0);
    check("rst_baddr", 64'(beat_addr), 64'd0);
    axi_aresetn = 1'b1;

    // single beat
    rvalid_in = 1'b1;
    rready_in = 1'b1;
    q.delete();
    req(32'h100, 8'd0, 3'd3, BURST_INCR);
    check("t1_arvalid", 64'(axi_arvalid), 64'd1);
    check("t1_araddr", 64'(axi_araddr), 64'h100);
    wait_beats(1);
    chk_beat(0, 32'h100, 1'b1);
    check("t1_arready", 64'(axi_arready), 64'd1);
    check("t1_rvalid", 64'(axi_rvalid), 64'd0);

    // INCR with backpressure
    q.delete();
    rr_mode = 1'b1;
    req(32'h1000, 8'd3, 3'd2, BURST_INCR);
    wait_beats(4);
    chk_beat(0, 32'h1000, 1'b0);
    chk_beat(1, 32'h1004, 1'b0);
    chk_beat(2, 32'h1008, 1'b0);
    chk_beat(3, 32'h100C, 1'b1);
    repeat (6) @(posedge axi_aclk);
    #1 check("t2_count", 64'(q.size()), 64'd4);
    rr_mode   = 1'b0;
    rready_in = 1'b1;

    // WRAP
    q.delete();
    req(32'h38, 8'd3, 3'd3, BURST_WRAP);
    wait_beats(4);
    chk_beat(0, 32'h38, 1'b0);
    chk_beat(1, 32'h20, 1'b0);
    chk_beat(2, 32'h28, 1'b0);
    chk_beat(3, 32'h30, 1'b1);

    // second request queued behind a stalled burst
    q.delete();
    ar_cnt    = 0;
    rready_in = 1'b0;
    req(32'h200, 8'd3, 3'd2, BURST_INCR);
    for (int i = 0; i < 50; i++) begin
      @(posedge axi_aclk);
      if (ar_cnt >= 1) break;
    end
    #1;
    check("t4_ar_first", 64'(ar_cnt), 64'd1);
    araddr_in  = 32'h400;
    arlen_in   = 8'd0;
    arsize_in  = 3'd3;
    arburst_in = BURST_INCR;
    arvalid_in = 1'b1;
    repeat (3) @(posedge axi_aclk);
    #1;
    check("t4_arvalid", 64'(axi_arvalid), 64'd1);
    check("t4_arready", 64'(axi_arready), 64'd0);
    check("t4_araddr", 64'(axi_araddr), 64'h400);
    rready_in = 1'b1;
    wait_beats(4);
    check("t4_arready_up", 64'(axi_arready), 64'd1);
    check("t4_arvalid_up", 64'(axi_arvalid), 64'd1);
    check("t4_ar_held", 64'(ar_cnt), 64'd1);
    chk_beat(3, 32'h20C, 1'b1);
    arvalid_in = 1'b0;
    @(negedge axi_aclk);
    #1 check("t4_ar_second", 64'(ar_cnt), 64'd2);
    wait_beats(5);
    chk_beat(4, 32'h400, 1'b1);

    // data before any AR, then error response
    repeat (3) begin
      @(posedge axi_aclk);
      #1 check("t5_early", 64'(axi_rvalid), 64'd0);
    end
    q.delete();
    rresp_in = RESP_SLVERR;
    req(32'h80, 8'd1, 3'd2, BURST_INCR);
    for (int i = 0; i < 50; i++) begin
      @(posedge axi_aclk);
      #1;
      if (axi_rvalid) break;
    end
    rresp_in = RESP_OKAY;
    wait_beats(2);
    chk_beat(0, 32'h80, 1'b0);
    chk_beat(1, 32'h84, 1'b1);
    check("t5_resp0", 64'(q[0].resp), 64'(RESP_SLVERR));
    check("t5_resp1", 64'(q[1].resp), 64'(RESP_OKAY));

    // reset mid-burst
    q.delete();
    req(32'h1000, 8'd3, 3'd2, BURST_INCR);
    wait_beats(1);
    axi_aresetn = 1'b0;
    @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    check("t6_arvalid", 64'(axi_arvalid), 64'd0);
    check("t6_rvalid", 64'(axi_rvalid), 64'd0);
    check("t6_rlast", 64'(axi_rlast), 64'd0);
    check("t6_arready", 64'(axi_arready), 64'd1);
    repeat (4) @(posedge axi_aclk);
    #1 check("t6_abandon", 64'(q.size()), 64'd1);
    q.delete();
    req(32'h500, 8'd1, 3'd2, BURST_INCR);
    wait_beats(2);
    chk_beat(0, 32'h500, 1'b0);
    chk_beat(1, 32'h504, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
